apb_reg_slave: RTL and testbench
================================

Name: apb_reg_slave

Overview:
Parametrised APB4 completer holding a bank of NUM_REGS read/write registers.
- Supports configurable wait states, byte strobes and error response on bad addresses.
- Exports register contents and per-register write pulses to the surrounding RTL.
- Sits behind the ifApbMaster-style bus as the standard register target for generated RegisterRTL blocks and the UVM environment.

Parameters:
ADDR_W, 32, width of paddr.
DATA_W, 32, data width; must be 8, 16 or 32.
NUM_REGS, 8, number of registers, 1..256.
WAIT_CYCLES, 0, pready-low cycles inserted in every access phase, 0..15.
BASE_ADDR, 0, byte address of register 0; must be aligned to DATA_W/8.

Ports:
pclk  in  1  APB clock; all logic on the rising edge.
preset_n  in  1  asynchronous active-low reset.
psel  in  1  slave select.
penable  in  1  access-phase indicator.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address.
pwdata  in  DATA_W  write data.
pstrb  in  DATA_W/8  write byte strobes.
pprot  in  3  protection attributes; accepted, not decoded.
prdata  out  DATA_W  read data.
pready  out  1  transfer completion.
pslverr  out  1  error response.
reg_q  out  NUM_REGS*DATA_W  flattened register contents; register i at bits [i*DATA_W +: DATA_W].
reg_wr  out  NUM_REGS  one-cycle pulse, bit i set the cycle after register i is written.

Behaviour:
- Reset (async, preset_n=0):
  - all registers 0; reg_wr 0.
  - FSM to IDLE; wait counter 0.
  - pready 0, pslverr 0, prdata 0.
- FSM states and transitions:
  - IDLE -> SETUP on psel & ~penable.
  - SETUP: latch paddr, pwrite, pwdata, pstrb, and compute err; go to ACCESS.
  - ACCESS -> IDLE when pready=1, or immediately if psel drops (abort: no write, no error).
- Decode:
  - off = paddr - BASE_ADDR (ADDR_W bits, wrap-around arithmetic).
  - err = (off mod DATA_W/8 != 0) | (off/(DATA_W/8) >= NUM_REGS). An address below BASE_ADDR wraps and therefore errors.
- Wait counter:
  - cleared in SETUP; increments each ACCESS cycle with psel & penable while cnt < WAIT_CYCLES.
  - pready = (state==ACCESS) & psel & penable & (cnt==WAIT_CYCLES), registered-state-derived combinational.
  - WAIT_CYCLES=0 gives pready in the first access cycle (zero-wait APB).
  - WAIT_CYCLES=N gives N low cycles, then 1 high.
- pslverr = pready & err; 0 whenever pready=0.
- Write commit on the pready=1 cycle when pwrite & ~err:
  - byte k of the addressed register takes pwdata byte k iff pstrb[k].
  - reg_wr[idx] pulses the next cycle.
  - pstrb=0 leaves data unchanged but still pulses reg_wr.
- Read: prdata = register[idx] when pready & ~pwrite & ~err, else 0. pstrb is ignored on reads.
- Error write: no register change, no reg_wr pulse.
- Latched values are used throughout the transfer; changes to paddr/pwdata in ACCESS are ignored.
- Back-to-back: ACCESS -> IDLE, then the next SETUP in the following cycle. The minimum transfer is 2 cycles.
- Reset asserted mid-transfer aborts immediately; registers clear.

Optional Feature:
APB_REG_SLAVE_WPROT_EN:
- Defined:
  - adds input port wprot_en (1 bit).
  - while wprot_en=1 at the pready cycle, writes are rejected: pslverr=1, no register change, no reg_wr pulse. Reads are unaffected.
  - err_total = err | (pwrite & wprot_en).
- Undefined: the port is absent and writes are never protection-blocked.

Test Plan:
- Reset, then read all 8 regs (defaults) -> prdata=0x00000000, pslverr=0, pready high in 2nd cycle of each transfer.
- Write 0xDEADBEEF to 0x08 with pstrb=0xF, then read 0x08 -> 0xDEADBEEF; reg_wr=8'b0000_0100 for one cycle.
- Write 0x11223344 to 0x08 with pstrb=4'b0101 over 0xDEADBEEF -> read 0xDE22BE44.
- WAIT_CYCLES=3: write to 0x04 -> pready low 3 access cycles, high on 4th; psel dropped after 1 wait cycle -> reg unchanged, FSM IDLE.
- Write to 0x20 (NUM_REGS=8) and to 0x06 (misaligned) -> pslverr=1 with pready, all regs unchanged, no reg_wr.
- WPROT_EN defined, wprot_en=1: write 0x55 to 0x00 -> pslverr=1, reg0 stays 0; wprot_en=0 then same write -> reg0=0x55.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB4 completer with a bank of NUM_REGS read/write registers,
// configurable wait states, byte strobes and an error response for bad addresses.
// Optional build macro APB_REG_SLAVE_WPROT_EN adds a wprot_en input that rejects
// writes with pslverr while it is high.
module apb_reg_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                       pclk,
    input  logic                       preset_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    input  logic [2:0]                 pprot,
`ifdef APB_REG_SLAVE_WPROT_EN
    input  logic                       wprot_en,
`endif
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // The setup phase is recognised while in IDLE; its clock edge latches the
    // request and enters ACCESS, so a zero-wait transfer completes in the
    // second bus cycle and back-to-back transfers need no extra state.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                err_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q;

    logic                setup_phase;
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   word_idx;
    logic                bad_addr;
    logic                err_now;
    logic                commit;

    // Protection attributes are accepted but carry no meaning for this target.
    logic unused_pprot;
    assign unused_pprot = ^pprot;

    assign setup_phase = psel & ~penable;

    // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range.
    assign off      = paddr - BASE_ADDR;
    assign word_idx = off / ADDR_W'(STRB_W);
    assign bad_addr = ((off % ADDR_W'(STRB_W)) != '0) || (word_idx >= ADDR_W'(NUM_REGS));

    assign pready = (state_q == ACCESS) & psel & penable & (cnt_q == 4'(WAIT_CYCLES));

`ifdef APB_REG_SLAVE_WPROT_EN
    assign err_now = err_q | (wr_q & wprot_en);
`else
    assign err_now = err_q;
`endif

    assign pslverr = pready & err_now;
    assign commit  = pready & wr_q & ~err_now;
    assign prdata  = (pready & ~wr_q & ~err_now) ? regs[idx_q] : '0;
    assign reg_wr  = reg_wr_q;

    // Flatten the register bank so surrounding logic sees every register at once.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    // State register for the transfer FSM.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave ACCESS on completion or when the requester aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || pready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request in the setup phase and count wait cycles during ACCESS.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (state_q == IDLE && setup_phase) begin
            cnt_q   <= '0;
            idx_q   <= word_idx[IDX_W-1:0];
            err_q   <= bad_addr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end else if (state_q == ACCESS && psel && penable && cnt_q < 4'(WAIT_CYCLES)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Commit strobed bytes on the completing cycle and pulse the write flag once.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= '0;
            if (commit) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (strb_q[k]) begin
                        regs[idx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
                    end
                end
                reg_wr_q[idx_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed bench for apb_reg_slave with two instances,
// one zero-wait at base 0 and one with three wait states at base 0x40.
// Protection tests are compiled in when APB_REG_SLAVE_WPROT_EN is defined.
module tb_apb_reg_slave;

    logic         pclk;
    logic         preset_n;
    logic         psel0;
    logic         psel1;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
`ifdef APB_REG_SLAVE_WPROT_EN
    logic         wprot_en;
`endif

    logic [31:0]  prdata0, prdata1;
    logic         pready0, pready1;
    logic         pslverr0, pslverr1;
    logic [255:0] reg_q0, reg_q1;
    logic [7:0]   reg_wr0, reg_wr1;

    logic         cur_dut;
    logic         sel_pready;
    logic         sel_pslverr;
    logic [31:0]  sel_prdata;
    logic [7:0]   sel_reg_wr;

    int           check_count;
    int           error_count;
    logic [255:0] exp_q0;
    logic [255:0] exp_q1;

    assign sel_pready  = cur_dut ? pready1  : pready0;
    assign sel_pslverr = cur_dut ? pslverr1 : pslverr0;
    assign sel_prdata  = cur_dut ? prdata1  : prdata0;
    assign sel_reg_wr  = cur_dut ? reg_wr1  : reg_wr0;

    apb_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)
    ) dut0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
`ifdef APB_REG_SLAVE_WPROT_EN
        .wprot_en(wprot_en),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .reg_q(reg_q0), .reg_wr(reg_wr0)
    );

    apb_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0040)
    ) dut1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
`ifdef APB_REG_SLAVE_WPROT_EN
        .wprot_en(1'b0),
`endif
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
        .reg_q(reg_q1), .reg_wr(reg_wr1)
    );

    // Free-running 100 MHz clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Hard stop in case a transfer never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One complete transfer, setup phase driven immediately so calls chain back-to-back.
    task automatic applyStimulus(input logic dut, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb, input logic scramble,
                                 output logic [31:0] rdata, output logic slverr,
                                 output int waits, output logic [7:0] wr_pulse);
        logic done;
        rdata   = '0;
        slverr  = 1'b0;
        waits   = 0;
        done    = 1'b0;
        cur_dut = dut;
        if (dut) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = 3'b010;
        @(negedge pclk);
        checkOutput("setup_pready", 256'(sel_pready), 256'(0));
        @(posedge pclk);
        #1;
        penable = 1'b1;
        if (scramble) begin
            paddr  = addr ^ 32'h0000_001C;
            pwdata = ~data;
        end
        while (!done && waits < 40) begin
            @(negedge pclk);
            if (sel_pready) begin
                rdata  = sel_prdata;
                slverr = sel_pslverr;
                done   = 1'b1;
            end else begin
                waits++;
            end
        end
        checkOutput("pready_seen", 256'(done), 256'(1));
        @(posedge pclk);
        #1;
        wr_pulse = sel_reg_wr;
        psel0    = 1'b0;
        psel1    = 1'b0;
        penable  = 1'b0;
    endtask

    task automatic writeCheck(input string tag, input logic dut, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb, input logic scramble,
                              input logic exp_err, input int exp_waits, input logic [7:0] exp_pulse);
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic [7:0]  pulse;
        applyStimulus(dut, 1'b1, addr, data, strb, scramble, rd, err, waits, pulse);
        checkOutput({tag, "_slverr"}, 256'(err), 256'(exp_err));
        checkOutput({tag, "_waits"}, 256'(waits), 256'(exp_waits));
        checkOutput({tag, "_reg_wr"}, 256'(pulse), 256'(exp_pulse));
    endtask

    task automatic readCheck(input string tag, input logic dut, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic [7:0]  pulse;
        applyStimulus(dut, 1'b0, addr, 32'h0, 4'hF, 1'b0, rd, err, waits, pulse);
        checkOutput({tag, "_prdata"}, 256'(rd), 256'(exp_data));
        checkOutput({tag, "_slverr"}, 256'(err), 256'(exp_err));
        checkOutput({tag, "_waits"}, 256'(waits), 256'(exp_waits));
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        exp_q0      = '0;
        exp_q1      = '0;
        cur_dut     = 1'b0;
        preset_n    = 1'b0;
        psel0       = 1'b0;
        psel1       = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        pstrb       = '0;
        pprot       = '0;
`ifdef APB_REG_SLAVE_WPROT_EN
        wprot_en    = 1'b0;
`endif

        repeat (2) @(negedge pclk);
        checkOutput("rst_pready0", 256'(pready0), 256'(0));
        checkOutput("rst_pslverr0", 256'(pslverr0), 256'(0));
        checkOutput("rst_prdata0", 256'(prdata0), 256'(0));
        checkOutput("rst_reg_q0", reg_q0, 256'(0));
        checkOutput("rst_reg_wr0", 256'(reg_wr0), 256'(0));
        checkOutput("rst_pready1", 256'(pready1), 256'(0));
        #2 preset_n = 1'b1;
        @(posedge pclk);
        #1;

        $display("[TB] zero-wait instance: default reads");
        for (int i = 0; i < 8; i++) begin
            readCheck("dflt_rd", 1'b0, 32'(i * 4), 32'h0000_0000, 1'b0, 0);
        end

        $display("[TB] zero-wait instance: writes and strobes");
        writeCheck("wr08_full", 1'b0, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 0, 8'b0000_0100);
        exp_q0[2*32 +: 32] = 32'hDEAD_BEEF;
        @(posedge pclk);
        #1;
        checkOutput("reg_wr_one_cycle", 256'(reg_wr0), 256'(0));
        readCheck("rd08_full", 1'b0, 32'h08, 32'hDEAD_BEEF, 1'b0, 0);
        checkOutput("reg_q0_after_full", reg_q0, exp_q0);

        writeCheck("wr08_strb5", 1'b0, 32'h08, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 0, 8'b0000_0100);
        exp_q0[2*32 +: 32] = 32'hDE22_BE44;
        readCheck("rd08_strb5", 1'b0, 32'h08, 32'hDE22_BE44, 1'b0, 0);

        writeCheck("wr08_strb0", 1'b0, 32'h08, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 0, 8'b0000_0100);
        readCheck("rd08_strb0", 1'b0, 32'h08, 32'hDE22_BE44, 1'b0, 0);

        writeCheck("wr1c_last", 1'b0, 32'h1C, 32'hA5A5_0F0F, 4'hF, 1'b0, 1'b0, 0, 8'b1000_0000);
        exp_q0[7*32 +: 32] = 32'hA5A5_0F0F;
        readCheck("rd1c_last", 1'b0, 32'h1C, 32'hA5A5_0F0F, 1'b0, 0);

        writeCheck("wr0c_latched", 1'b0, 32'h0C, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, 0, 8'b0000_1000);
        exp_q0[3*32 +: 32] = 32'h0BAD_F00D;
        readCheck("rd0c_latched", 1'b0, 32'h0C, 32'h0BAD_F00D, 1'b0, 0);
        readCheck("rd10_untouched", 1'b0, 32'h10, 32'h0000_0000, 1'b0, 0);

        $display("[TB] zero-wait instance: bad addresses");
        writeCheck("wr20_range", 1'b0, 32'h20, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 0, 8'h00);
        checkOutput("reg_q0_after_wr20", reg_q0, exp_q0);
        writeCheck("wr06_misalign", 1'b0, 32'h06, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 0, 8'h00);
        checkOutput("reg_q0_after_wr06", reg_q0, exp_q0);
        readCheck("rd20_range", 1'b0, 32'h20, 32'h0000_0000, 1'b1, 0);
        readCheck("rd0a_misalign", 1'b0, 32'h0A, 32'h0000_0000, 1'b1, 0);

        $display("[TB] wait-state instance");
        writeCheck("w3_wr44", 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 3, 8'b0000_0010);
        exp_q1[1*32 +: 32] = 32'hCAFE_F00D;

        // Abort: requester drops psel after one wait cycle of a write.
        cur_dut = 1'b1;
        psel1   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h44;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        checkOutput("abort_wait_pready", 256'(pready1), 256'(0));
        @(posedge pclk);
        #1;
        psel1   = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        checkOutput("abort_idle_pready", 256'(pready1), 256'(0));
        checkOutput("abort_idle_pslverr", 256'(pslverr1), 256'(0));
        @(posedge pclk);
        #1;
        checkOutput("abort_reg_wr", 256'(reg_wr1), 256'(0));
        checkOutput("abort_reg_q1", reg_q1, exp_q1);

        readCheck("w3_rd44", 1'b1, 32'h44, 32'hCAFE_F00D, 1'b0, 3);
        writeCheck("w3_wr3c_below", 1'b1, 32'h3C, 32'h0000_00AA, 4'hF, 1'b0, 1'b1, 3, 8'h00);
        writeCheck("w3_wr60_range", 1'b1, 32'h60, 32'h0000_00BB, 4'hF, 1'b0, 1'b1, 3, 8'h00);
        writeCheck("w3_wr5c_last", 1'b1, 32'h5C, 32'hDEAD_0001, 4'hF, 1'b0, 1'b0, 3, 8'b1000_0000);
        exp_q1[7*32 +: 32] = 32'hDEAD_0001;
        readCheck("w3_rd5c_last", 1'b1, 32'h5C, 32'hDEAD_0001, 1'b0, 3);
        checkOutput("reg_q1_final", reg_q1, exp_q1);

`ifdef APB_REG_SLAVE_WPROT_EN
        $display("[TB] write protection");
        wprot_en = 1'b1;
        writeCheck("wprot_wr00", 1'b0, 32'h00, 32'h0000_0055, 4'hF, 1'b0, 1'b1, 0, 8'h00);
        checkOutput("wprot_reg_q0", reg_q0, exp_q0);
        readCheck("wprot_rd00", 1'b0, 32'h00, 32'h0000_0000, 1'b0, 0);
        wprot_en = 1'b0;
        writeCheck("unprot_wr00", 1'b0, 32'h00, 32'h0000_0055, 4'hF, 1'b0, 1'b0, 0, 8'b0000_0001);
        exp_q0[0*32 +: 32] = 32'h0000_0055;
        readCheck("unprot_rd00", 1'b0, 32'h00, 32'h0000_0055, 1'b0, 0);
`endif

        checkOutput("reg_q0_before_reset", reg_q0, exp_q0);

        $display("[TB] reset during a transfer");
        cur_dut = 1'b0;
        psel0   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h00;
        pwdata  = 32'h0000_0077;
        pstrb   = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #2 preset_n = 1'b0;
        #1;
        checkOutput("midrst_reg_q0", reg_q0, 256'(0));
        checkOutput("midrst_reg_q1", reg_q1, 256'(0));
        checkOutput("midrst_pready0", 256'(pready0), 256'(0));
        psel0   = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        @(posedge pclk);
        #1;
        checkOutput("midrst_reg_wr0", 256'(reg_wr0), 256'(0));
        readCheck("midrst_rd08", 1'b0, 32'h08, 32'h0000_0000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
